// File: rtl/ram_multi_read_clear_if.sv
// Port bundle for ram_multi_read_clear: clear request, ready flag, the read ports and the masked write port.
// The master side drives addresses, data and requests, and the slave side is the RAM.
interface ram_multi_read_clear_if #(
  parameter int DEPTH      = 16,
  parameter int SIZE       = 16,
  parameter int READ_PORTS = 2,
  parameter int LANE       = 8
);
  localparam int ADDR_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int MASK_WIDTH = DEPTH / LANE;

  logic                             aClear;
  logic                             anOutReady;
  logic [READ_PORTS*ADDR_WIDTH-1:0] aReadAddress;
  logic [READ_PORTS-1:0]            aReadEnable;
  logic [READ_PORTS*DEPTH-1:0]      anOutReadData;
  logic [ADDR_WIDTH-1:0]            aWriteAddress;
  logic [DEPTH-1:0]                 aWriteData;
  logic [MASK_WIDTH-1:0]            aWriteMask;
  logic                             aWriteEnable;

  modport master (
    output aClear, aReadAddress, aReadEnable, aWriteAddress, aWriteData, aWriteMask, aWriteEnable,
    input  anOutReady, anOutReadData
  );

  modport slave (
    input  aClear, aReadAddress, aReadEnable, aWriteAddress, aWriteData, aWriteMask, aWriteEnable,
    output anOutReady, anOutReadData
  );
endinterface

// File: rtl/ram_multi_read_clear.sv
// Multi-read, single-write RAM with per-lane write masks and write-first bypass.
// A hardware sweep zeroes every entry after reset or on a clear request.
module ram_multi_read_clear #(
  parameter int DEPTH           = 16,
  parameter int SIZE            = 16,
  parameter int READ_PORTS      = 2,
  parameter int LANE            = 8,
  parameter bit REGISTERED_READ = 1'b0
) (
  input  logic                    aClock,
  input  logic                    aReset,
  ram_multi_read_clear_if.slave   bus
);
  localparam int ADDR_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int MASK_WIDTH = DEPTH / LANE;
  localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH + 1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_s;
  logic                  wr_eff_s;
  logic [DEPTH-1:0]      mem_r [SIZE];
  logic [DEPTH-1:0]      rd_s  [READ_PORTS];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < SIZE_W);
  endfunction

  function automatic logic [DEPTH-1:0] merge_lanes(input logic [DEPTH-1:0] old_v,
                                                   input logic [DEPTH-1:0] new_v,
                                                   input logic [MASK_WIDTH-1:0] mask_v);
    logic [DEPTH-1:0] res;
    res = old_v;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (mask_v[i]) begin
        res[i*LANE +: LANE] = new_v[i*LANE +: LANE];
      end else begin
        res[i*LANE +: LANE] = old_v[i*LANE +: LANE];
      end
    end
    return res;
  endfunction

  assign wr_eff_s       = bus.aWriteEnable && (state_r == READY) && in_range(bus.aWriteAddress);
  assign bus.anOutReady = (state_r == READY);

  // State register and sweep counter
  always_ff @(posedge aClock) begin
    if (aReset) begin
      state_r <= CLEAR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Sweep sequencing; a clear request is only honoured once the RAM is ready
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      CLEAR: begin
        if (cnt_r == LAST_W) begin
          state_s = READY;
          cnt_s   = '0;
        end else begin
          cnt_s   = cnt_r + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        if (bus.aClear) begin
          state_s = CLEAR;
          cnt_s   = '0;
        end else begin
          state_s = READY;
        end
      end
      default: begin
        state_s = CLEAR;
        cnt_s   = '0;
      end
    endcase
  end

  // Storage: sweep writes zero, otherwise the masked user write lands
  always_ff @(posedge aClock) begin
    if (!aReset) begin
      if (state_r == CLEAR) begin
        mem_r[cnt_r] <= '0;
      end else if (wr_eff_s) begin
        mem_r[bus.aWriteAddress] <= merge_lanes(mem_r[bus.aWriteAddress], bus.aWriteData, bus.aWriteMask);
      end
    end
  end

  for (genvar gp = 0; gp < READ_PORTS; gp++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr_s;
    assign addr_s = bus.aReadAddress[gp*ADDR_WIDTH +: ADDR_WIDTH];

    // Per-port read with write-first merge when the write hits the same entry
    always_comb begin
      rd_s[gp] = '0;
      if ((state_r == READY) && bus.aReadEnable[gp] && in_range(addr_s)) begin
        if (wr_eff_s && (bus.aWriteAddress == addr_s)) begin
          rd_s[gp] = merge_lanes(mem_r[addr_s], bus.aWriteData, bus.aWriteMask);
        end else begin
          rd_s[gp] = mem_r[addr_s];
        end
      end else begin
        rd_s[gp] = '0;
      end
    end

    if (REGISTERED_READ) begin : g_reg
      logic [DEPTH-1:0] rd_r;

      // Capture the merged read result; zero under reset
      always_ff @(posedge aClock) begin
        if (aReset) begin
          rd_r <= '0;
        end else begin
          rd_r <= rd_s[gp];
        end
      end

      assign bus.anOutReadData[gp*DEPTH +: DEPTH] = rd_r;
    end else begin : g_comb
      assign bus.anOutReadData[gp*DEPTH +: DEPTH] = rd_s[gp];
    end
  end
endmodule

// File: tb/tb_ram_multi_read_clear.sv
// Bench for ram_multi_read_clear: three instances (combinational/16, registered/16, combinational/12)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_ram_multi_read_clear;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int RP = 2;
  localparam int MW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              clr;
  logic              we;
  logic [RP*AW-1:0]  ra;
  logic [RP-1:0]     re;
  logic [AW-1:0]     wa;
  logic [DW-1:0]     wd;
  logic [MW-1:0]     wm;

  ram_multi_read_clear_if #(.DEPTH(16), .SIZE(16), .READ_PORTS(2), .LANE(8)) b0 ();
  ram_multi_read_clear_if #(.DEPTH(16), .SIZE(16), .READ_PORTS(2), .LANE(8)) b1 ();
  ram_multi_read_clear_if #(.DEPTH(16), .SIZE(12), .READ_PORTS(2), .LANE(8)) b2 ();

  assign b0.aClear = clr;  assign b1.aClear = clr;  assign b2.aClear = clr;
  assign b0.aReadAddress = ra;  assign b1.aReadAddress = ra;  assign b2.aReadAddress = ra;
  assign b0.aReadEnable = re;  assign b1.aReadEnable = re;  assign b2.aReadEnable = re;
  assign b0.aWriteAddress = wa;  assign b1.aWriteAddress = wa;  assign b2.aWriteAddress = wa;
  assign b0.aWriteData = wd;  assign b1.aWriteData = wd;  assign b2.aWriteData = wd;
  assign b0.aWriteMask = wm;  assign b1.aWriteMask = wm;  assign b2.aWriteMask = wm;
  assign b0.aWriteEnable = we;  assign b1.aWriteEnable = we;  assign b2.aWriteEnable = we;

  ram_multi_read_clear #(.DEPTH(16), .SIZE(16), .READ_PORTS(2), .LANE(8), .REGISTERED_READ(1'b0))
    dut0 (.aClock(clk), .aReset(rst), .bus(b0));
  ram_multi_read_clear #(.DEPTH(16), .SIZE(16), .READ_PORTS(2), .LANE(8), .REGISTERED_READ(1'b1))
    dut1 (.aClock(clk), .aReset(rst), .bus(b1));
  ram_multi_read_clear #(.DEPTH(16), .SIZE(12), .READ_PORTS(2), .LANE(8), .REGISTERED_READ(1'b0))
    dut2 (.aClock(clk), .aReset(rst), .bus(b2));

  // Behavioural model: contents, edges left before ready, last captured registered read.
  logic [15:0] mem [3][16];
  int          remaining [3];
  int          sz [3]   = '{16, 16, 12};
  bit          regd [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] regexp [3];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] comb_exp(input int k, input int p);
    int          a;
    logic [15:0] v;
    a = int'(ra[p*AW +: AW]);
    if (remaining[k] != 0 || !re[p] || a >= sz[k]) return 16'h0000;
    v = mem[k][a];
    if (we && int'(wa) < sz[k] && int'(wa) == a)
      for (int b = 0; b < 16; b++) if (wm[b/8]) v[b] = wd[b];
    return v;
  endfunction

  function automatic logic [31:0] dut_out(input int k);
    case (k)
      0:       return b0.anOutReadData;
      1:       return b1.anOutReadData;
      default: return b2.anOutReadData;
    endcase
  endfunction

  function automatic logic dut_rdy(input int k);
    case (k)
      0:       return b0.anOutReady;
      1:       return b1.anOutReady;
      default: return b2.anOutReady;
    endcase
  endfunction

  task automatic check_cycle();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] o;
      o = dut_out(k);
      chk($sformatf("ready[%0d]", k), {31'd0, dut_rdy(k)}, {31'd0, remaining[k] == 0});
      for (int p = 0; p < RP; p++)
        chk($sformatf("rdata[%0d][%0d]", k, p), {16'd0, o[p*16 +: 16]},
            {16'd0, regd[k] ? regexp[k][p*16 +: 16] : comb_exp(k, p)});
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] nxt;
      for (int p = 0; p < RP; p++) nxt[p*16 +: 16] = comb_exp(k, p);
      if (rst) begin
        remaining[k] = sz[k];
        regexp[k] = 32'd0;
      end else begin
        regexp[k] = nxt;
        if (remaining[k] != 0) begin
          remaining[k]--;
          if (remaining[k] == 0) for (int i = 0; i < 16; i++) mem[k][i] = 16'h0000;
        end else begin
          if (we && int'(wa) < sz[k])
            for (int b = 0; b < 16; b++) if (wm[b/8]) mem[k][wa][b] = wd[b];
          if (clr) remaining[k] = sz[k];
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step(input bit do_check);
    @(negedge clk);
    if (do_check) check_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit w, input int waddr, input logic [15:0] d,
                       input logic [1:0] m, input logic [1:0] e, input int a0, input int a1);
    clr = c;  we = w;  wa = AW'(waddr);  wd = d;  wm = m;  re = e;
    ra = {AW'(a1), AW'(a0)};
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      remaining[k] = sz[k];
      regexp[k] = 32'd0;
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 16'h0, 2'b00, 2'b00, 0, 0);
    step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("reset_ready", {31'd0, b0.anOutReady}, 32'd0);
    chk("reset_regout", b1.anOutReadData, 32'd0);

    // Sweep after reset release: all reads zero, ready after SIZE edges
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 0, 16'h0, 2'b00, 2'b11, i - 1, 16 - i);
      chk("sweep_read0", {16'd0, b0.anOutReadData[15:0]}, 32'd0);
      step(1'b1);
      chk("sweep_ready16", {31'd0, b0.anOutReady}, {31'd0, i == 16});
      chk("sweep_ready12", {31'd0, b2.anOutReady}, {31'd0, i >= 12});
    end

    // Masked write with same-cycle bypass
    drive(1'b0, 1'b1, 5, 16'hAAAA, 2'b11, 2'b00, 0, 0);  step(1'b1);
    drive(1'b0, 1'b1, 5, 16'h1234, 2'b01, 2'b01, 5, 0);
    chk("bypass_comb", {16'd0, b0.anOutReadData[15:0]}, 32'h0000AA34);
    step(1'b1);
    chk("bypass_reg", {16'd0, b1.anOutReadData[15:0]}, 32'h0000AA34);
    drive(1'b0, 1'b0, 0, 16'h0, 2'b00, 2'b01, 5, 0);
    chk("masked_stored", {16'd0, b0.anOutReadData[15:0]}, 32'h0000AA34);
    step(1'b1);

    // Dual read ports
    drive(1'b0, 1'b1, 2, 16'h0011, 2'b11, 2'b00, 0, 0);  step(1'b1);
    drive(1'b0, 1'b1, 3, 16'h0022, 2'b11, 2'b00, 0, 0);  step(1'b1);
    drive(1'b0, 1'b0, 0, 16'h0, 2'b00, 2'b11, 2, 3);
    chk("dual_read", b0.anOutReadData, 32'h00220011);
    step(1'b1);
    drive(1'b0, 1'b0, 0, 16'h0, 2'b00, 2'b11, 3, 3);
    chk("same_addr", b0.anOutReadData, 32'h00220022);
    step(1'b1);

    // Registered read latency and registered bypass
    drive(1'b0, 1'b1, 7, 16'h0BEE, 2'b11, 2'b00, 0, 0);  step(1'b1);
    drive(1'b0, 1'b0, 0, 16'h0, 2'b00, 2'b01, 7, 0);
    chk("regread_now", {16'd0, b1.anOutReadData[15:0]}, 32'd0);
    step(1'b1);
    chk("regread_next", {16'd0, b1.anOutReadData[15:0]}, 32'h00000BEE);
    drive(1'b0, 1'b1, 7, 16'h1111, 2'b11, 2'b01, 7, 0);  step(1'b1);
    chk("regread_bypass", {16'd0, b1.anOutReadData[15:0]}, 32'h00001111);

    // Out-of-range write on the 12-entry instance
    drive(1'b0, 1'b1, 13, 16'hFFFF, 2'b11, 2'b00, 0, 0);  step(1'b1);
    drive(1'b0, 1'b0, 0, 16'h0, 2'b00, 2'b01, 13, 0);
    chk("oob_read12", {16'd0, b2.anOutReadData[15:0]}, 32'd0);
    chk("inrange_read16", {16'd0, b0.anOutReadData[15:0]}, 32'h0000FFFF);
    step(1'b1);

    // Runtime clear: request edge plus SIZE sweep edges; writes during sweep dropped
    drive(1'b1, 1'b1, 1, 16'h5555, 2'b11, 2'b01, 1, 0);  step(1'b1);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, i - 1, 16'h9999, 2'b11, 2'b11, i - 1, 0);
      chk("clear_ready_low", {31'd0, b0.anOutReady}, 32'd0);
      step(1'b1);
    end
    chk("clear_ready_high", {31'd0, b0.anOutReady}, 32'd1);

    // Reset in the middle of a sweep restarts it
    drive(1'b1, 1'b0, 0, 16'h0, 2'b00, 2'b00, 0, 0);  step(1'b1);
    drive(1'b0, 1'b0, 0, 16'h0, 2'b00, 2'b11, 4, 9);
    for (int i = 0; i < 8; i++) step(1'b1);
    rst = 1'b1;  step(1'b1);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1);
      chk("restart_ready", {31'd0, b0.anOutReady}, {31'd0, i == 16});
    end

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int waddr;
      waddr = $urandom_range(0, 15);
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, waddr, 16'($urandom),
            2'($urandom), 2'($urandom),
            ($urandom_range(0, 2) == 0) ? waddr : int'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0) ? waddr : int'($urandom_range(0, 15)));
      step(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_multi_read_clear.md
# ram_multi_read_clear

Parametrised multi-read-port, single-write-port RAM with per-lane write masks, selectable combinational or registered read, same-cycle write bypass, and a hardware clear sequencer that zeroes every entry after reset or on request. It replaces the simple 1R/1W RAM wherever register files, tag stores or scratch tables need more than one read per cycle or a known-zero initial state.

## Interface
- DEPTH, 16: bits per word (word width); must be a multiple of LANE.
- SIZE, 16: number of entries; need not be a power of two.
- READ_PORTS, 2: number of independent read ports, ≥1.
- LANE, 8: bits per write-mask lane; MASK_WIDTH = DEPTH/LANE.
- REGISTERED_READ, 0: 0 = combinational read, 1 = one-cycle registered read.
- ADDR_WIDTH (local): $clog2(SIZE), minimum 1.

Ports:
- aClock  in  1  single clock, all state updates on rising edge.
- aReset  in  1  synchronous, active-high reset.
- aClear  in  1  request a full clear sweep (sampled in READY only).
- anOutReady  out  1  high when RAM is usable (state READY).
- aReadAddress  in  READ_PORTS×ADDR_WIDTH  per-port read address.
- aReadEnable  in  READ_PORTS  per-port read enable.
- anOutReadData  out  READ_PORTS×DEPTH  per-port read data.
- aWriteAddress  in  ADDR_WIDTH  write address.
- aWriteData  in  DEPTH  write data.
- aWriteMask  in  MASK_WIDTH  lane i writes bits [i*LANE +: LANE] when set.
- aWriteEnable  in  1  write enable.

## Operation
- States: CLEAR, READY. Clear counter ADDR_WIDTH bits.
- aReset high at an edge: state CLEAR, counter 0, no memory write that cycle, registered read outputs 0.
- CLEAR, aReset low: each edge writes all-zero to mem[counter], counter increments; on the edge that clears entry SIZE-1, state → READY, counter → 0.
- READY, aClear high at an edge: state → CLEAR, counter 0; a write qualified in that same cycle is still performed (it is then cleared by the sweep).
- aClear ignored in CLEAR (no restart); aReset always restarts the sweep.
- In CLEAR: user writes dropped; all anOutReadData = 0; anOutReady = 0.
- Effective write: aWriteEnable && state READY && aWriteAddress < SIZE; only lanes with mask bit set change.
- Read result per port p: aReadEnable[p] low or address ≥ SIZE → 0. Otherwise mem[addr], with bypass: if an effective write targets the same address this cycle, masked lanes take aWriteData, unmasked lanes take stored value (write-first merge).
- Multiple ports reading the same address receive identical data.
- Write at address ≥ SIZE: ignored, no aliasing.

## Timing
- REGISTERED_READ=0: anOutReadData combinational from addresses, enables, write inputs and state, same cycle; memory updates visible to non-bypassed reads the cycle after the write edge.
- REGISTERED_READ=1: read result computed as above (including bypass merge) and captured at the edge; valid one cycle after address presented. Output holds 0 after reset and for any cycle whose sampled state was CLEAR.
- Reset values: anOutReady 0, state CLEAR, counter 0, registered outputs 0. Memory contents undefined until the sweep completes.
- Clear latency: anOutReady rises exactly SIZE cycles after the first edge with aReset low (after aClear: SIZE+1 edges including the request edge).
- Reset asserted mid-sweep: sweep restarts from 0 on release; full SIZE cycles again.
- Throughput: one write and READ_PORTS reads every cycle in READY, no stalls.

## Test plan
- Reset then sweep, SIZE=16: hold aReset 3 cycles, release → anOutReady low for 16 cycles, high on 17th; all ports read 0 at every address.
- Masked write/bypass, DEPTH=16, LANE=8: mem[5]=0xAAAA; write 0x1234 mask 2'b01 to 5 while port 0 reads 5 → combinational read 0xAA34 same cycle; next cycle stored 0xAA34.
- Dual read: write 0x0011 @2, 0x0022 @3; same cycle read port0@2, port1@3 → 0x0011, 0x0022; both ports @3 → 0x0022 each.
- Registered mode: REGISTERED_READ=1, read @7 (holding 0x0BEE) → 0 this cycle, 0x0BEE next; same-cycle write 0x1111 full mask @7 → next-cycle output 0x1111.
- Runtime clear and mid-sweep reset: aClear in READY → anOutReady low 16 cycles, writes during sweep dropped, reads 0; assert aReset at sweep cycle 8 → full 16-cycle sweep from release.
- Non-power-of-two SIZE=12: write 0xFFFF @13 → no entry changes; read @13 → 0; sweep length 12 cycles.
